// File: rtl/dc_pred_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dc_pred_arbiter_pkg
// Desc     : Shared state encoding, defaults and slice helpers for the
//            DC predictor arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dc_pred_arbiter_pkg;

    localparam int c_STATE_W = 4;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 4'b0001;
    localparam logic [c_STATE_W-1:0] c_ST_ISSUE = 4'b0010;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT  = 4'b0100;
    localparam logic [c_STATE_W-1:0] c_ST_RESP  = 4'b1000;

    localparam int c_TIMEOUT_DEFAULT = 64;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // LSB of requester idx within a packed bus of w-bit slices
    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dc_pred_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dc_pred_arbiter_rr_arbiter
// Desc     : Combinational round-robin grant, searching upward from i_rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module dc_pred_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // wrap rr_ptr + k back into 0..NUM_REQ-1 without a divider
            w_sum = {1'b0, i_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            w_cand = w_sum[ID_W-1:0];
            if (!o_grant_any && i_req[w_cand]) begin
                o_grant_any     = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dc_pred_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dc_pred_arbiter
// Desc     : Shares one DC predictor between NUM_REQ requesters, returning the
//            predicted block (or a timeout error) with the requester id.
// Revision : 1.0 - initial release
// ============================================================================
module dc_pred_arbiter
    import dc_pred_arbiter_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int BLOCK_SIZE = 16,
    parameter int BLOCK_NUM  = 10,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = id_width(NUM_REQ),
    parameter int TIMEOUT    = c_TIMEOUT_DEFAULT
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*BLOCK_NUM-1:0]               req_x,
    input  logic [NUM_REQ*BLOCK_NUM-1:0]               req_y,
    input  logic [NUM_REQ*BIT_WIDTH*BLOCK_SIZE-1:0]    req_top,
    input  logic [NUM_REQ*BIT_WIDTH*BLOCK_SIZE-1:0]    req_left,
    output logic                                       pred_start,
    output logic [BLOCK_NUM-1:0]                       pred_x,
    output logic [BLOCK_NUM-1:0]                       pred_y,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            pred_top,
    output logic [BIT_WIDTH*BLOCK_SIZE-1:0]            pred_left,
    input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] pred_dst,
    input  logic                                       pred_done,
    output logic                                       rsp_valid,
    input  logic                                       rsp_ready,
    output logic [ID_W-1:0]                            rsp_id,
    output logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] rsp_dst,
    output logic                                       rsp_err,
    output logic                                       busy
);

    localparam int ROW_W = BIT_WIDTH * BLOCK_SIZE;
    localparam int BLK_W = ROW_W * BLOCK_SIZE;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  c_ID_LAST  = ID_W'(NUM_REQ - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [ID_W-1:0]      r_rr_ptr;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_pred_start;
    logic [BLOCK_NUM-1:0] r_pred_x, r_pred_y;
    logic [ROW_W-1:0]     r_pred_top, r_pred_left;
    logic                 r_rsp_valid, r_rsp_err;
    logic [ID_W-1:0]      r_rsp_id;
    logic [BLK_W-1:0]     r_rsp_dst;

    logic [NUM_REQ-1:0]   w_grant;
    logic [ID_W-1:0]      w_grant_idx;
    logic                 w_grant_any;
    logic [BLOCK_NUM-1:0] w_x    [NUM_REQ];
    logic [BLOCK_NUM-1:0] w_y    [NUM_REQ];
    logic [ROW_W-1:0]     w_top  [NUM_REQ];
    logic [ROW_W-1:0]     w_left [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_x[gi]    = req_x[slice_lsb(gi, BLOCK_NUM) +: BLOCK_NUM];
            assign w_y[gi]    = req_y[slice_lsb(gi, BLOCK_NUM) +: BLOCK_NUM];
            assign w_top[gi]  = req_top[slice_lsb(gi, ROW_W) +: ROW_W];
            assign w_left[gi] = req_left[slice_lsb(gi, ROW_W) +: ROW_W];
        end
    endgenerate

    dc_pred_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_grant_any)
    );

    // Ready is held low during reset so no requester sees a phantom accept.
    assign req_ready  = (r_state == c_ST_IDLE && !rst) ? w_grant : '0;
    assign busy       = (r_state != c_ST_IDLE);
    assign pred_start = r_pred_start;
    assign pred_x     = r_pred_x;
    assign pred_y     = r_pred_y;
    assign pred_top   = r_pred_top;
    assign pred_left  = r_pred_left;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;
    assign rsp_id     = r_rsp_id;
    assign rsp_dst    = r_rsp_dst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_timer      <= '0;
            r_pred_start <= 1'b0;
            r_pred_x     <= '0;
            r_pred_y     <= '0;
            r_pred_top   <= '0;
            r_pred_left  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_dst    <= '0;
        end else begin
            r_pred_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_any) begin
                        r_pred_x     <= w_x[w_grant_idx];
                        r_pred_y     <= w_y[w_grant_idx];
                        r_pred_top   <= w_top[w_grant_idx];
                        r_pred_left  <= w_left[w_grant_idx];
                        r_rsp_id     <= w_grant_idx;
                        r_rr_ptr     <= (w_grant_idx == c_ID_LAST) ? '0 : w_grant_idx + 1'b1;
                        r_pred_start <= 1'b1;
                        r_state      <= c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_timer <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // done on the final timer cycle still counts as success
                    if (pred_done) begin
                        r_rsp_dst   <= pred_dst;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_rsp_dst   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dc_pred_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_pred_arbiter
// Desc     : Self-checking bench: vector table plus corner-case sequences,
//            with a response scoreboard and a behavioural predictor model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_pred_arbiter;

    localparam int BW    = 8;
    localparam int BS    = 16;
    localparam int BN    = 10;
    localparam int NR    = 4;
    localparam int IW    = 2;
    localparam int TO    = 64;
    localparam int ROW_W = BW * BS;
    localparam int BLK_W = ROW_W * BS;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*BN-1:0]  req_x, req_y;
    logic [NR*ROW_W-1:0] req_top, req_left;
    logic              pred_start;
    logic [BN-1:0]     pred_x, pred_y;
    logic [ROW_W-1:0]  pred_top, pred_left;
    logic [BLK_W-1:0]  pred_dst;
    logic              pred_done = 1'b0;
    logic              rsp_valid, rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [BLK_W-1:0]  rsp_dst;
    logic              rsp_err, busy;

    dc_pred_arbiter #(
        .BIT_WIDTH (BW), .BLOCK_SIZE (BS), .BLOCK_NUM (BN),
        .NUM_REQ (NR), .ID_W (IW), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_x (req_x), .req_y (req_y), .req_top (req_top), .req_left (req_left),
        .pred_start (pred_start), .pred_x (pred_x), .pred_y (pred_y),
        .pred_top (pred_top), .pred_left (pred_left),
        .pred_dst (pred_dst), .pred_done (pred_done),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
        .rsp_dst (rsp_dst), .rsp_err (rsp_err), .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Predictor model: done m_delay cycles after the start cycle (never if < 2),
    // block filled with the average of the first top and left samples.
    int         m_delay = -1;
    int         m_cnt   = 0;
    logic [7:0] m_fill;
    always @(posedge clk) begin
        pred_done <= 1'b0;
        if (pred_start) m_cnt <= 1;
        else if (m_cnt > 0) m_cnt <= m_cnt + 1;
        if (m_cnt > 0 && m_delay >= 2 && m_cnt == m_delay - 1) begin
            pred_done <= 1'b1;
            m_cnt     <= 0;
        end
    end
    always_comb m_fill = 8'((9'(pred_top[7:0]) + 9'(pred_left[7:0])) >> 1);
    assign pred_dst = {(BS*BS){m_fill}};

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { int id; logic [7:0] fill; bit err; } exp_t;
    exp_t sb_q[$];

    typedef struct { logic [NR-1:0] mask; int delay; int exp_id; } vec_t;
    vec_t vecs[9];

    logic [7:0] top_b  [NR];
    logic [7:0] left_b [NR];

    function automatic logic [7:0] exp_fill(input int id);
        return 8'((9'(top_b[id]) + 9'(left_b[id])) >> 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, want);
    endtask

    task automatic chk_blk(input string name, input logic [BLK_W-1:0] act, input logic [7:0] fill);
        logic [BLK_W-1:0] want;
        want = {(BS*BS){fill}};
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got first byte %h, want every byte %h", name, act[7:0], fill);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: got response id %0d, want none", rsp_id);
            return;
        end
        e = sb_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk_blk("rsp_dst", rsp_dst, e.err ? 8'h00 : e.fill);
    endtask

    // Called at a drive point; returns at the sample point of the start cycle.
    task automatic issue(input logic [NR-1:0] mask, input int delay, input int want_id,
                         input bit want_err, output int a_cyc, output int s_cyc);
        exp_t e;
        int   k;
        m_delay   = delay;
        req_valid = mask;
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            step();
            #1;
            k++;
        end
        chk("req_ready", 64'(req_ready), 64'(1) << want_id);
        a_cyc  = cyc;
        e.id   = want_id;
        e.fill = exp_fill(want_id);
        e.err  = want_err;
        sb_q.push_back(e);
        step();
        req_valid = '0;
        #1;
        s_cyc = cyc;
        chk("pred_start", 64'(pred_start), 64'(1));
        chk("pred_x", 64'(pred_x), 64'(3 + 100*want_id));
        chk("pred_y", 64'(pred_y), 64'(2 + 50*want_id));
        chk("pred_top", 64'(pred_top[ROW_W-1 -: 8]), 64'(top_b[want_id]));
        chk("pred_left", 64'(pred_left[7:0]), 64'(left_b[want_id]));
    endtask

    task automatic wait_rsp(input int limit, output int r_cyc, output int starts);
        int k;
        k      = 0;
        starts = 0;
        while (!rsp_valid && k < limit) begin
            step();
            #1;
            k++;
            if (pred_start) starts++;
        end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, want 1", limit);
        end
        r_cyc = cyc;
        if (rsp_valid && rsp_ready) sb_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, s, r, st, bad;

        top_b  = '{8'h10, 8'h40, 8'h60, 8'h80};
        left_b = '{8'h30, 8'h20, 8'h00, 8'hF0};
        for (int i = 0; i < NR; i++) begin
            req_x[i*BN +: BN]          = BN'(3 + 100*i);
            req_y[i*BN +: BN]          = BN'(2 + 50*i);
            req_top[i*ROW_W +: ROW_W]  = {BS{top_b[i]}};
            req_left[i*ROW_W +: ROW_W] = {BS{left_b[i]}};
        end

        vecs[0] = '{4'b1111, 4, 0};
        vecs[1] = '{4'b1111, 5, 1};
        vecs[2] = '{4'b1111, 3, 2};
        vecs[3] = '{4'b1111, 4, 3};
        vecs[4] = '{4'b1111, 6, 0};
        vecs[5] = '{4'b1001, 4, 3};
        vecs[6] = '{4'b0110, 2, 1};
        vecs[7] = '{4'b0011, 4, 0};
        vecs[8] = '{4'b1000, 2, 3};

        // reset state
        rst       = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        step();
        step();
        #1;
        chk("ready_in_rst", 64'(req_ready), 64'(0));
        step();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_pred_start", 64'(pred_start), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_pred_x", 64'(pred_x), 64'(0));
        chk_blk("rst_rsp_dst", rsp_dst, 8'h00);

        // vector table: round-robin order and latency with rsp_ready held high
        for (int v = 0; v < 9; v++) begin
            step();
            issue(vecs[v].mask, vecs[v].delay, vecs[v].exp_id, 1'b0, a, s);
            wait_rsp(100, r, st);
            chk("latency", 64'(r - a), 64'(vecs[v].delay + 2));
        end

        // single request, 18-cycle predictor
        step();
        issue(4'b0001, 18, 0, 1'b0, a, s);
        chk("single_start_lat", 64'(s - a), 64'(1));
        wait_rsp(100, r, st);
        chk("single_rsp_lat", 64'(r - a), 64'(20));
        chk("single_start_once", 64'(st), 64'(0));

        // timeout: predictor never completes
        step();
        issue(4'b0100, -1, 2, 1'b1, a, s);
        wait_rsp(100, r, st);
        chk("timeout_lat", 64'(r - s), 64'(65));
        step();
        #1;
        chk("timeout_err_clr", 64'(rsp_err), 64'(0));
        chk("timeout_valid_clr", 64'(rsp_valid), 64'(0));

        // done on the last timer cycle wins over the timeout
        step();
        issue(4'b1000, 64, 3, 1'b0, a, s);
        wait_rsp(100, r, st);
        chk("collide_lat", 64'(r - s), 64'(65));

        // backpressure
        step();
        rsp_ready = 1'b0;
        issue(4'b0010, 4, 1, 1'b0, a, s);
        wait_rsp(100, r, st);
        for (int k = 0; k < 10; k++) begin
            step();
            req_valid = 4'b1111;
            #1;
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_id", 64'(rsp_id), 64'(1));
            chk("bp_err", 64'(rsp_err), 64'(0));
            chk_blk("bp_dst", rsp_dst, exp_fill(1));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_pred_start", 64'(pred_start), 64'(0));
        end
        step();
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        sb_check();
        step();
        #1;
        chk("bp_idle_busy", 64'(busy), 64'(0));
        chk("bp_idle_valid", 64'(rsp_valid), 64'(0));
        step();
        issue(4'b1111, 4, 2, 1'b0, a, s);
        wait_rsp(100, r, st);

        // reset in WAIT abandons the job; the late done must be ignored
        step();
        issue(4'b0010, 18, 1, 1'b0, a, s);
        repeat (5) step();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_valid", 64'(rsp_valid), 64'(0));
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            #1;
            if (rsp_valid || busy) bad++;
        end
        chk("mid_rst_quiet", 64'(bad), 64'(0));
        step();
        issue(4'b0110, 4, 1, 1'b0, a, s);
        wait_rsp(100, r, st);
        step();
        issue(4'b0100, 4, 2, 1'b0, a, s);
        wait_rsp(100, r, st);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
